// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave transmit path.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_SINGLE = 2'b00,
    SPI_DUAL   = 2'b01,
    SPI_QUAD   = 2'b10
  } spi_mode_e;

  localparam logic [3:0] LANE_MASK_SINGLE = 4'b0001;
  localparam logic [3:0] LANE_MASK_DUAL   = 4'b0011;
  localparam logic [3:0] LANE_MASK_QUAD   = 4'b1111;

  // Encoding 11 is reserved and falls back to single-lane operation.
  function automatic spi_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return SPI_DUAL;
      2'b10:   return SPI_QUAD;
      default: return SPI_SINGLE;
    endcase
  endfunction

  function automatic int unsigned lanes(input spi_mode_e m);
    case (m)
      SPI_DUAL: return 2;
      SPI_QUAD: return 4;
      default:  return 1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input spi_mode_e m);
    case (m)
      SPI_DUAL: return LANE_MASK_DUAL;
      SPI_QUAD: return LANE_MASK_QUAD;
      default:  return LANE_MASK_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_tx_multi_if.sv
// Word-source and pad-side signals of the multi-lane SPI slave transmitter.
interface spi_slave_tx_multi_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic [1:0]            mode_i;
  logic [CNT_WIDTH-1:0]  len_i;
  logic                  len_upd_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  data_valid_i;
  logic                  data_ready_o;
  logic [3:0]            sdo_o;
  logic [3:0]            sdo_oe_o;
  logic                  done_o;
  logic                  underrun_o;

  modport master (
    output mode_i, len_i, len_upd_i, data_i, data_valid_i,
    input  data_ready_o, sdo_o, sdo_oe_o, done_o, underrun_o
  );

  modport slave (
    input  mode_i, len_i, len_upd_i, data_i, data_valid_i,
    output data_ready_o, sdo_o, sdo_oe_o, done_o, underrun_o
  );
endinterface

// File: rtl/spi_slave_tx_fifo.sv
// Small synchronous word buffer; push into full and pop from empty are ignored.
module spi_slave_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/spi_slave_tx_multi.sv
// Multi-lane SPI slave transmit shifter with word buffer, per-transfer mode and sticky underrun.
module spi_slave_tx_multi
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic               sclk,
  input  logic               rstn,
  spi_slave_tx_multi_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(DATA_WIDTH);

  logic                  running_q, running_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, trgt_q, trgt_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  spi_mode_e             mode_q, mode_d;
  logic                  underrun_q, underrun_d;

  logic                  load_c;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  function automatic logic [WCNT_W-1:0] word_last(input spi_mode_e m);
    case (m)
      SPI_DUAL: return WCNT_W'(DATA_WIDTH / 2 - 1);
      SPI_QUAD: return WCNT_W'(DATA_WIDTH / 4 - 1);
      default:  return WCNT_W'(DATA_WIDTH - 1);
    endcase
  endfunction

  spi_slave_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rstn    (rstn),
    .push_i  (bus.data_valid_i),
    .data_i  (bus.data_i),
    .pop_i   (load_c),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Start/restart has priority over the running sequence; reloads pop the buffer.
  always_comb begin
    running_d  = running_q;
    cnt_d      = cnt_q;
    trgt_d     = trgt_q;
    wcnt_d     = wcnt_q;
    shreg_d    = shreg_q;
    mode_d     = mode_q;
    underrun_d = underrun_q;
    load_c     = 1'b0;

    if (bus.len_upd_i) begin
      trgt_d    = bus.len_i;
      mode_d    = decode_mode(bus.mode_i);
      running_d = 1'b1;
      cnt_d     = '0;
      wcnt_d    = '0;
      load_c    = 1'b1;
    end else if (running_q) begin
      if (cnt_q == trgt_q) begin
        running_d = 1'b0;
        cnt_d     = '0;
        wcnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (wcnt_q == word_last(mode_q)) begin
          load_c = 1'b1;
          wcnt_d = '0;
        end else begin
          shreg_d = shreg_q << lanes(mode_q);
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
    end

    if (load_c) begin
      if (fifo_empty) begin
        shreg_d    = '0;
        underrun_d = 1'b1;
      end else begin
        shreg_d = fifo_head;
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      running_q  <= 1'b0;
      cnt_q      <= '0;
      trgt_q     <= CNT_WIDTH'(7);
      wcnt_q     <= '0;
      shreg_q    <= '0;
      mode_q     <= SPI_SINGLE;
      underrun_q <= 1'b0;
    end else begin
      running_q  <= running_d;
      cnt_q      <= cnt_d;
      trgt_q     <= trgt_d;
      wcnt_q     <= wcnt_d;
      shreg_q    <= shreg_d;
      mode_q     <= mode_d;
      underrun_q <= underrun_d;
    end
  end

  // MSB-first lane mapping; lanes above the active width stay low.
  always_comb begin
    case (mode_q)
      SPI_QUAD: bus.sdo_o = shreg_q[DATA_WIDTH-1 -: 4];
      SPI_DUAL: bus.sdo_o = {2'b00, shreg_q[DATA_WIDTH-1 -: 2]};
      default:  bus.sdo_o = {3'b000, shreg_q[DATA_WIDTH-1]};
    endcase
  end

  assign bus.sdo_oe_o     = running_q ? lane_mask(mode_q) : 4'b0000;
  assign bus.done_o       = running_q && (cnt_q == trgt_q);
  assign bus.underrun_o   = underrun_q;
  assign bus.data_ready_o = !fifo_full;

endmodule

// File: tb/tb_spi_slave_tx_multi.sv
// Scoreboard bench for spi_slave_tx_multi: expected lane beats are queued by stimulus, checked by a monitor.
module tb_spi_slave_tx_multi;

  typedef struct packed {
    logic [3:0] sdo;
    logic [3:0] oe;
    logic       done;
  } beat_t;

  logic  sclk;
  logic  rstn;
  int    checks;
  int    errors;
  beat_t exp_q[$];

  spi_slave_tx_multi_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

  spi_slave_tx_multi #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (2),
    .CNT_WIDTH  (8)
  ) dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] sdo, input logic [3:0] oe, input logic done);
    beat_t b;
    b.sdo  = sdo;
    b.oe   = oe;
    b.done = done;
    exp_q.push_back(b);
  endtask

  task automatic exp_quad(input logic [31:0] word, input logic done_last);
    for (int i = 0; i < 8; i++)
      push_exp(word[31-4*i -: 4], 4'b1111, done_last && (i == 7));
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.data_i       = w;
    bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
  endtask

  task automatic start_xfer(input logic [1:0] mode, input logic [7:0] len);
    bus.mode_i    = mode;
    bus.len_i     = len;
    bus.len_upd_i = 1'b1;
    tick();
    bus.len_upd_i = 1'b0;
  endtask

  // Monitor: every active lane cycle must match the next queued beat.
  always @(negedge sclk) begin
    if (rstn && bus.sdo_oe_o != 4'b0000) begin
      beat_t act;
      beat_t exp;
      act.sdo  = bus.sdo_o;
      act.oe   = bus.sdo_oe_o;
      act.done = bus.done_o;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected sdo=%b oe=%b done=%b at %0t", act.sdo, act.oe, act.done, $time);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL beat: got sdo=%b oe=%b done=%b expected sdo=%b oe=%b done=%b at %0t",
                   act.sdo, act.oe, act.done, exp.sdo, exp.oe, exp.done, $time);
        end
      end
    end
  end

  initial begin
    logic [31:0] pat;
    logic [1:0]  dual_pat [4];
    checks = 0;
    errors = 0;
    rstn             = 1'b0;
    bus.mode_i       = 2'b00;
    bus.len_i        = '0;
    bus.len_upd_i    = 1'b0;
    bus.data_i       = '0;
    bus.data_valid_i = 1'b0;

    #12;
    chk("reset_sdo",      32'(bus.sdo_o),        32'h0);
    chk("reset_oe",       32'(bus.sdo_oe_o),     32'h0);
    chk("reset_done",     32'(bus.done_o),       32'h0);
    chk("reset_underrun", 32'(bus.underrun_o),   32'h0);
    chk("reset_ready",    32'(bus.data_ready_o), 32'h1);
    rstn = 1'b1;
    tick();

    // Single lane, MSB first
    pat = 32'b1010_0101_1010_0101_0000_1111_0000_1111;
    for (int i = 0; i < 32; i++) push_exp({3'b000, pat[31-i]}, 4'b0001, i == 31);
    push_word(32'hA5A5_0F0F);
    start_xfer(2'b00, 8'd31);
    repeat (32) tick();
    chk("single_underrun", 32'(bus.underrun_o), 32'h0);

    // Quad lane, one word
    exp_quad(32'h1234_5678, 1'b1);
    push_word(32'h1234_5678);
    start_xfer(2'b10, 8'd7);
    repeat (8) tick();

    // Dual lane, two seamless words
    dual_pat[0] = 2'b11; dual_pat[1] = 2'b00; dual_pat[2] = 2'b00; dual_pat[3] = 2'b11;
    for (int i = 0; i < 32; i++) push_exp({2'b00, dual_pat[i/8]}, 4'b0011, i == 31);
    push_word(32'hFFFF_0000);
    push_word(32'h0000_FFFF);
    start_xfer(2'b01, 8'd31);
    repeat (32) tick();
    chk("dual_underrun", 32'(bus.underrun_o), 32'h0);
    chk("dual_drained_ready", 32'(bus.data_ready_o), 32'h1);

    // Full buffer back-pressure, then drain three quad words
    exp_quad(32'h0123_4567, 1'b0);
    exp_quad(32'h89AB_CDEF, 1'b0);
    exp_quad(32'hFEDC_BA98, 1'b1);
    bus.data_valid_i = 1'b1;
    bus.data_i = 32'h0123_4567;
    tick();
    bus.data_i = 32'h89AB_CDEF;
    tick();
    chk("full_ready_low", 32'(bus.data_ready_o), 32'h0);
    bus.data_i = 32'hFEDC_BA98;
    tick();
    chk("full_ready_held", 32'(bus.data_ready_o), 32'h0);
    start_xfer(2'b10, 8'd23);
    chk("full_ready_after_pop", 32'(bus.data_ready_o), 32'h1);
    tick();
    bus.data_valid_i = 1'b0;
    chk("full_third_accepted", 32'(bus.data_ready_o), 32'h0);
    repeat (23) tick();
    chk("full_underrun", 32'(bus.underrun_o), 32'h0);

    // Underrun: second word of the transfer is missing
    exp_quad(32'h1234_5678, 1'b0);
    for (int i = 0; i < 8; i++) push_exp(4'h0, 4'b1111, i == 7);
    push_word(32'h1234_5678);
    start_xfer(2'b10, 8'd15);
    repeat (7) tick();
    chk("underrun_before_reload", 32'(bus.underrun_o), 32'h0);
    tick();
    chk("underrun_at_reload", 32'(bus.underrun_o), 32'h1);
    repeat (8) tick();
    chk("underrun_sticky", 32'(bus.underrun_o), 32'h1);

    // Restart mid-transfer in quad mode
    push_exp(4'h1, 4'b1111, 1'b0);
    push_exp(4'h2, 4'b1111, 1'b0);
    push_exp(4'h3, 4'b1111, 1'b0);
    exp_quad(32'h9ABC_DEF0, 1'b1);
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    start_xfer(2'b10, 8'd7);
    repeat (2) tick();
    start_xfer(2'b10, 8'd7);
    repeat (8) tick();

    // Reset at cycle 5 of a single-lane transfer, with an extra word buffered
    push_exp(4'h1, 4'b0001, 1'b0);
    push_exp(4'h0, 4'b0001, 1'b0);
    push_exp(4'h1, 4'b0001, 1'b0);
    push_exp(4'h0, 4'b0001, 1'b0);
    push_word(32'hA5A5_0F0F);
    push_word(32'h0000_0000);
    start_xfer(2'b00, 8'd31);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    chk("rst_mid_sdo",      32'(bus.sdo_o),        32'h0);
    chk("rst_mid_oe",       32'(bus.sdo_oe_o),     32'h0);
    chk("rst_mid_done",     32'(bus.done_o),       32'h0);
    chk("rst_mid_ready",    32'(bus.data_ready_o), 32'h1);
    chk("rst_mid_underrun", 32'(bus.underrun_o),   32'h0);
    #1;
    rstn = 1'b1;
    tick();

    // Buffer must have been flushed: a fresh transfer underruns at its start edge
    for (int i = 0; i < 4; i++) push_exp(4'h0, 4'b1111, i == 3);
    start_xfer(2'b10, 8'd3);
    chk("flush_underrun", 32'(bus.underrun_o), 32'h1);
    repeat (4) tick();
    chk("final_ready", 32'(bus.data_ready_o), 32'h1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
